// File: rtl/approx_mac_pkg.sv
// Shared types and default widths for the approximate-multiplier dot-product accumulator.
package approx_mac_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/approx_mult_dot_accumulator_if.sv
// Product-in / sum-out handshake bundle. The producer/consumer side uses master, the accumulator uses slave.
interface approx_mult_dot_accumulator_if #(
  parameter int PROD_W = approx_mac_pkg::PROD_W_DEF,
  parameter int ACC_W  = approx_mac_pkg::ACC_W_DEF,
  parameter int LEN_W  = approx_mac_pkg::LEN_W_DEF
) ();

  logic [LEN_W-1:0]  cfg_len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic              busy;

  modport master (
    output cfg_len, in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  cfg_len, in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );

endinterface

// File: rtl/approx_mult_dot_accumulator_acc_sat_add.sv
// Combinational ACC_W-bit unsigned add with carry-out; clamps to all-ones on carry
// when APPROX_MAC_SATURATE_EN is defined, otherwise wraps.
module acc_sat_add #(
  parameter int ACC_W = approx_mac_pkg::ACC_W_DEF
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[ACC_W];
`ifdef APPROX_MAC_SATURATE_EN
    sum   = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    sum   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/approx_mult_dot_accumulator.sv
// Groups cfg_len unsigned products into one sum with valid/ready on both sides.
// Overflow handling selected by APPROX_MAC_SATURATE_EN (saturate + sticky flag) or wrap when undefined.
module approx_mult_dot_accumulator
  import approx_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  approx_mult_dot_accumulator_if.slave  bus
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic [LEN_W-1:0] cnt_inc;

`ifdef APPROX_MAC_SATURATE_EN
  logic ovf_q, ovf_d;
  logic add_carry;
`else
  logic add_carry_unused;
`endif

  assign prod_ext = ACC_W'(bus.in_prod);
  assign cnt_inc  = cnt_q + LEN_W'(1);

  acc_sat_add #(.ACC_W(ACC_W)) u_add (
    .a     (acc_q),
    .b     (prod_ext),
    .sum   (add_sum),
`ifdef APPROX_MAC_SATURATE_EN
    .carry (add_carry)
`else
    .carry (add_carry_unused)
`endif
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef APPROX_MAC_SATURATE_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d   = prod_ext;
          cnt_d   = LEN_W'(1);
          // A zero length would never terminate, so it runs as a single-beat group.
          len_d   = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
`ifdef APPROX_MAC_SATURATE_EN
          ovf_d   = 1'b0;
`endif
          state_d = (len_d == LEN_W'(1)) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (bus.in_valid) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
`ifdef APPROX_MAC_SATURATE_EN
          ovf_d = ovf_q | add_carry;
`endif
          if (cnt_inc == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
`ifdef APPROX_MAC_SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
`ifdef APPROX_MAC_SATURATE_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake outputs depend only on registered state (plus reset masking of in_ready).
  assign bus.in_ready  = !rst && (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef APPROX_MAC_SATURATE_EN
  assign bus.out_ovf   = ovf_q;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: doc/approx_mult_dot_accumulator.md
# approx_mult_dot_accumulator

Accumulates a programmable number of 32-bit unsigned products from the 16x16 approximate multiplier into a single dot-product result. Sits directly downstream of the multiplier's P output, adding the valid/ready handshaking and state that the combinational multiplier lacks. Hands completed sums to the evaluation/error-metric logic.

## Interface
- PROD_W, 32: product width; matches multiplier P.
- ACC_W, 40: accumulator and result width; must be >= PROD_W.
- LEN_W, 8: width of the group-length field.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_len  in  LEN_W  products per group; sampled only on a group's first accepted beat.
- in_valid  in  1  in_prod holds a valid product.
- in_ready  out  1  block accepts a beat this cycle.
- in_prod  in  PROD_W  unsigned product from the multiplier.
- out_valid  out  1  out_sum holds a completed group result.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  group sum.
- out_ovf  out  1  sticky overflow flag for the current group.
- busy  out  1  a group is in progress or a result is being held.

## Operation
- A beat is accepted when in_valid && in_ready are both high on a clock edge.
- FSM states are IDLE, ACC and HOLD.
- IDLE:
  - in_ready=1.
  - On an accepted beat: acc<=in_prod, cnt<=1, len_q<=cfg_len (a cfg_len of 0 is treated as 1), ovf<=0.
  - If len_q==1, go to HOLD; otherwise go to ACC.
- ACC:
  - in_ready=1.
  - On each accepted beat: acc<=acc+in_prod (zero-extended to ACC_W), cnt<=cnt+1.
  - On the beat where cnt+1==len_q, go to HOLD.
  - Cycles with in_valid low are gaps: no state change.
- HOLD:
  - out_valid=1, in_ready=0.
  - out_sum and out_ovf are held stable.
  - When out_ready is high, go to IDLE.
- There is no new-group acceptance in HOLD. The consumer handshake and the next first beat are never in the same cycle.
- Arithmetic is unsigned. Overflow behaviour is set by the macro in Configuration.
- busy = (state != IDLE).
- cfg_len changes during ACC or HOLD have no effect.
- Asserting rst at any point, including mid-group, aborts the group with no partial result emitted.

## Timing
- Reset values:
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_sum=0, out_ovf=0, busy=0.
  - in_ready=0 while rst is high, and 1 from the first cycle after release.
- in_ready and out_valid are decoded combinationally from the registered state only. There is no combinational path from in_valid or out_ready to either signal.
- Latency: out_valid rises in the cycle after the final beat is accepted.
- Minimum group period is len_q+1 cycles, because HOLD costs at least 1 cycle.
- out_sum is driven directly from the acc register. It is valid whenever out_valid=1.

## Configuration
- Macro: APPROX_MAC_SATURATE_EN.
- Defined:
  - On carry-out of an accumulate, acc is clamped to 2^ACC_W-1 and ovf is set.
  - ovf is sticky until the next group's first beat.
  - Further adds keep the saturated value.
- Undefined:
  - acc wraps modulo 2^ACC_W.
  - out_ovf is tied to 0.
  - No saturation logic is synthesised.

## Structure
- Package approx_mac_pkg holds:
  - the FSM state enum (IDLE, ACC, HOLD);
  - default localparams for PROD_W, ACC_W and LEN_W.
- The sub-module acc_sat_add (ACC_W-bit add plus optional clamp, combinational) is natural. It takes acc and the zero-extended product and returns sum and carry. The macro is honoured inside it.
- The top level contains the FSM, counters, registers and handshake.

## Test plan
- Basic group: cfg_len=4, products 1,2,3,4 sent back-to-back -> out_valid one cycle after the 4th beat, out_sum=10, out_ovf=0.
- Zero length: cfg_len=0, single product 0xFFFF_FFFF -> treated as length 1; out_sum=0x00_FFFF_FFFF after 1 cycle.
- Backpressure: in HOLD with out_sum=10, out_ready low for 5 cycles while in_valid=1 and in_prod=7 -> in_ready=0, out_sum stays 10, no beat consumed. After out_ready pulses, the next group starts with 7.
- Overflow: ACC_W=33, cfg_len=3, three beats of 0xFFFF_FFFF:
  - macro defined -> out_sum=0x1_FFFF_FFFF, out_ovf=1;
  - macro undefined -> out_sum=0x0_FFFF_FFFD, out_ovf=0.
- Reset mid-group: cfg_len=4, accept 2 beats, pulse rst -> all outputs at reset values. Then cfg_len=2 with 5 and 6 -> out_sum=11.
- Gaps and len change: cfg_len=3, beats 2, 4, 8 separated by idle cycles, with cfg_len changed to 1 after the first beat -> out_sum=14 after exactly 3 beats.
